scoreboard_mp: RTL and testbench

- Parametrised successor to the fixed 8-warp, 4-entry, 2-clear-port scoreboard between IBuffer and issue.
- Tracks pending destination registers per warp.
- Flags RAW/WAW hazards to the IBuffer and hands out a free scoreboard ID (ScbID) on issue.
- Retires entries from NUM_CLR independent clear ports (ALU branch, CDB, MEM, ...).
- Warp count, entries per warp and register width are all generic.

---
 rtl/scb_mp_pkg.sv | 33 +++
 rtl/scb_warp_slice.sv | 111 +++++++++++
 rtl/scoreboard_mp.sv | 94 +++++++++
 tb/tb_scoreboard_mp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scb_mp_pkg.sv
// rtl/scb_mp_pkg.sv - shared defaults, entry record and error-bit indices for scoreboard_mp
package scb_mp_pkg;

    localparam int NUM_WARPS_DEF = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int REG_W_DEF     = 5;
    localparam int NUM_CLR_DEF   = 2;

    // dst field is sized for the widest register file we support; narrower builds zero-extend
    localparam int REG_W_MAX = 16;

    localparam int ERR_ALLOC_FULL = 0;
    localparam int ERR_CLR_IDLE   = 1;

    typedef struct packed {
        logic                 busy;
        logic                 dv;
        logic [REG_W_MAX-1:0] dst;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{busy: 1'b0, dv: 1'b0, dst: '0};

    function automatic logic reg_match(
        input logic                 live,
        input logic                 dv,
        input logic [REG_W_MAX-1:0] dst,
        input logic                 use_reg,
        input logic [REG_W_MAX-1:0] reg_id
    );
        return live && dv && use_reg && (dst == reg_id);
    endfunction

endpackage

// File: rtl/scb_warp_slice.sv
// rtl/scb_warp_slice.sv - one warp's entries, free-entry encoder, hazard compare, popcount (SCOREBOARD_MP_CLR_BYPASS_EN: same-cycle clear bypass)
module scb_warp_slice
    import scb_mp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int LOGD  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic [REG_W-1:0] dst,
    input  logic             src1_valid,
    input  logic             src2_valid,
    input  logic             dst_valid,
    input  logic [DEPTH-1:0] clr,
    output logic             full,
    output logic             empty,
    output logic             dependent,
    output logic [LOGD-1:0]  scb_id,
    output logic [LOGD:0]    count,
    output logic             alloc_err,
    output logic             clr_err
);

    entry_t               ent [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     live;
    logic [DEPTH-1:0]     busy_next;
    logic                 alloc_ok;
    logic [REG_W_MAX-1:0] src1_x;
    logic [REG_W_MAX-1:0] src2_x;
    logic [REG_W_MAX-1:0] dst_x;

    assign src1_x = REG_W_MAX'(src1);
    assign src2_x = REG_W_MAX'(src2);
    assign dst_x  = REG_W_MAX'(dst);

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            busy[e] = ent[e].busy;
        end
    end

    // live is the occupancy the issue side sees this cycle
`ifdef SCOREBOARD_MP_CLR_BYPASS_EN
    assign live = busy & ~clr;
`else
    assign live = busy;
`endif

    always_comb begin
        scb_id = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!live[e]) begin
                scb_id = LOGD'(e);
            end
        end
    end

    always_comb begin
        count = '0;
        for (int e = 0; e < DEPTH; e++) begin
            count = count + (LOGD + 1)'(live[e]);
        end
    end

    always_comb begin
        dependent = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (reg_match(live[e], ent[e].dv, ent[e].dst, src1_valid, src1_x) ||
                reg_match(live[e], ent[e].dv, ent[e].dst, src2_valid, src2_x) ||
                reg_match(live[e], ent[e].dv, ent[e].dst, dst_valid,  dst_x)) begin
                dependent = 1'b1;
            end
        end
    end

    assign full      = &live;
    assign empty     = ~|live;
    assign alloc_ok  = alloc & ~full;
    assign alloc_err = alloc & full;
    // duplicate clears of one busy entry collapse into a single bit, so they never flag here
    assign clr_err   = |(clr & ~busy);

    always_comb begin
        busy_next = busy & ~clr;
        if (alloc_ok) begin
            busy_next[scb_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent[e] <= ENTRY_RESET;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                ent[e].busy <= busy_next[e];
                if (alloc_ok && (scb_id == LOGD'(e))) begin
                    ent[e].dv  <= dst_valid;
                    ent[e].dst <= dst_x;
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_mp.sv
// rtl/scoreboard_mp.sv - multi-warp register scoreboard top: clear-port decode, warp slices, sticky errors (SCOREBOARD_MP_CLR_BYPASS_EN)
module scoreboard_mp
    import scb_mp_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int REG_W     = REG_W_DEF,
    parameter int NUM_CLR   = NUM_CLR_DEF,
    parameter int LOGW      = $clog2(NUM_WARPS),
    parameter int LOGD      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WARPS-1:0]          Alloc_IB_Scb,
    input  logic [REG_W*NUM_WARPS-1:0]    Src1_Flattened_IB_Scb,
    input  logic [REG_W*NUM_WARPS-1:0]    Src2_Flattened_IB_Scb,
    input  logic [REG_W*NUM_WARPS-1:0]    Dst_Flattened_IB_Scb,
    input  logic [NUM_WARPS-1:0]          Src1_Valid_IB_Scb,
    input  logic [NUM_WARPS-1:0]          Src2_Valid_IB_Scb,
    input  logic [NUM_WARPS-1:0]          Dst_Valid_IB_Scb,
    input  logic [NUM_CLR-1:0]            Clear_Valid_Scb,
    input  logic [LOGW*NUM_CLR-1:0]       Clear_WarpID_Flattened_Scb,
    input  logic [LOGD*NUM_CLR-1:0]       Clear_ScbID_Flattened_Scb,
    output logic [NUM_WARPS-1:0]          Full_Scb_IB,
    output logic [NUM_WARPS-1:0]          Empty_Scb_IB,
    output logic [NUM_WARPS-1:0]          Dependent_Scb_IB,
    output logic [LOGD*NUM_WARPS-1:0]     ScbID_Flattened_Scb_IB,
    output logic [(LOGD+1)*NUM_WARPS-1:0] Count_Scb,
    output logic [1:0]                    Err_Scb
);

    logic [DEPTH-1:0]     clr_vec [NUM_WARPS];
    logic [NUM_WARPS-1:0] alloc_err;
    logic [NUM_WARPS-1:0] clr_err;
    logic [1:0]           err;

    // warp IDs beyond NUM_WARPS match no slice and are dropped
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            clr_vec[w] = '0;
        end
        for (int p = 0; p < NUM_CLR; p++) begin
            if (Clear_Valid_Scb[p]) begin
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (Clear_WarpID_Flattened_Scb[p*LOGW +: LOGW] == LOGW'(w)) begin
                        clr_vec[w][Clear_ScbID_Flattened_Scb[p*LOGD +: LOGD]] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        scb_warp_slice #(
            .DEPTH (DEPTH),
            .REG_W (REG_W),
            .LOGD  (LOGD)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .alloc      (Alloc_IB_Scb[w]),
            .src1       (Src1_Flattened_IB_Scb[w*REG_W +: REG_W]),
            .src2       (Src2_Flattened_IB_Scb[w*REG_W +: REG_W]),
            .dst        (Dst_Flattened_IB_Scb[w*REG_W +: REG_W]),
            .src1_valid (Src1_Valid_IB_Scb[w]),
            .src2_valid (Src2_Valid_IB_Scb[w]),
            .dst_valid  (Dst_Valid_IB_Scb[w]),
            .clr        (clr_vec[w]),
            .full       (Full_Scb_IB[w]),
            .empty      (Empty_Scb_IB[w]),
            .dependent  (Dependent_Scb_IB[w]),
            .scb_id     (ScbID_Flattened_Scb_IB[w*LOGD +: LOGD]),
            .count      (Count_Scb[w*(LOGD+1) +: LOGD+1]),
            .alloc_err  (alloc_err[w]),
            .clr_err    (clr_err[w])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            if (|alloc_err) begin
                err[ERR_ALLOC_FULL] <= 1'b1;
            end
            if (|clr_err) begin
                err[ERR_CLR_IDLE] <= 1'b1;
            end
        end
    end

    assign Err_Scb = err;

endmodule

// File: tb/tb_scoreboard_mp.sv
// tb/tb_scoreboard_mp.sv - directed and random checks of scoreboard_mp against a behavioural model
module tb_scoreboard_mp;

    localparam int NW = 8, D = 4, RW = 5, NC = 2, LW = 3, LD = 2;
    localparam int NW2 = 16, D2 = 8, NC2 = 3, LW2 = 4, LD2 = 3;
`ifdef SCOREBOARD_MP_CLR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NW-1:0]        alloc, s1v, s2v, dv;
    logic [RW*NW-1:0]     s1, s2, dst;
    logic [NC-1:0]        cv;
    logic [LW*NC-1:0]     cw;
    logic [LD*NC-1:0]     cs;
    logic [NW-1:0]        full, empty, dep;
    logic [LD*NW-1:0]     sid;
    logic [(LD+1)*NW-1:0] cnt;
    logic [1:0]           err;

    logic [NW2-1:0]         b_alloc, b_s1v, b_s2v, b_dv;
    logic [RW*NW2-1:0]      b_s1, b_s2, b_dst;
    logic [NC2-1:0]         b_cv;
    logic [LW2*NC2-1:0]     b_cw;
    logic [LD2*NC2-1:0]     b_cs;
    logic [NW2-1:0]         b_full, b_empty, b_dep;
    logic [LD2*NW2-1:0]     b_sid;
    logic [(LD2+1)*NW2-1:0] b_cnt;
    logic [1:0]             b_err;

    int n_cmp = 0;
    int n_fail = 0;

    bit     m_busy [NW][D];
    bit     m_dv   [NW][D];
    int     m_dst  [NW][D];
    bit [1:0] m_err;

    scoreboard_mp u_dut (
        .clk(clk), .rst(rst), .Alloc_IB_Scb(alloc),
        .Src1_Flattened_IB_Scb(s1), .Src2_Flattened_IB_Scb(s2), .Dst_Flattened_IB_Scb(dst),
        .Src1_Valid_IB_Scb(s1v), .Src2_Valid_IB_Scb(s2v), .Dst_Valid_IB_Scb(dv),
        .Clear_Valid_Scb(cv), .Clear_WarpID_Flattened_Scb(cw), .Clear_ScbID_Flattened_Scb(cs),
        .Full_Scb_IB(full), .Empty_Scb_IB(empty), .Dependent_Scb_IB(dep),
        .ScbID_Flattened_Scb_IB(sid), .Count_Scb(cnt), .Err_Scb(err)
    );

    scoreboard_mp #(.NUM_WARPS(NW2), .DEPTH(D2), .REG_W(RW), .NUM_CLR(NC2)) u_big (
        .clk(clk), .rst(rst), .Alloc_IB_Scb(b_alloc),
        .Src1_Flattened_IB_Scb(b_s1), .Src2_Flattened_IB_Scb(b_s2), .Dst_Flattened_IB_Scb(b_dst),
        .Src1_Valid_IB_Scb(b_s1v), .Src2_Valid_IB_Scb(b_s2v), .Dst_Valid_IB_Scb(b_dv),
        .Clear_Valid_Scb(b_cv), .Clear_WarpID_Flattened_Scb(b_cw), .Clear_ScbID_Flattened_Scb(b_cs),
        .Full_Scb_IB(b_full), .Empty_Scb_IB(b_empty), .Dependent_Scb_IB(b_dep),
        .ScbID_Flattened_Scb_IB(b_sid), .Count_Scb(b_cnt), .Err_Scb(b_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit clr_hit(input int w, input int e);
        for (int p = 0; p < NC; p++) begin
            if (cv[p] && int'(cw[p*LW +: LW]) == w && int'(cs[p*LD +: LD]) == e) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit hazard(input int w, input int e);
        return m_dv[w][e] &&
               ((s1v[w] && m_dst[w][e] == int'(s1[w*RW +: RW])) ||
                (s2v[w] && m_dst[w][e] == int'(s2[w*RW +: RW])) ||
                (dv[w]  && m_dst[w][e] == int'(dst[w*RW +: RW])));
    endfunction

    task automatic model_check();
        logic [NW-1:0]        e_full, e_empty, e_dep;
        logic [LD*NW-1:0]     e_sid;
        logic [(LD+1)*NW-1:0] e_cnt;
        int n, first;
        bit live;
        for (int w = 0; w < NW; w++) begin
            n = 0;
            first = -1;
            e_dep[w] = 1'b0;
            for (int e = 0; e < D; e++) begin
                live = m_busy[w][e] && !(BYPASS && clr_hit(w, e));
                if (live) begin
                    n++;
                    if (hazard(w, e)) e_dep[w] = 1'b1;
                end else if (first < 0) begin
                    first = e;
                end
            end
            e_full[w]  = (n == D);
            e_empty[w] = (n == 0);
            e_sid[w*LD +: LD] = (first < 0) ? '0 : LD'(first);
            e_cnt[w*(LD+1) +: LD+1] = (LD+1)'(n);
        end
        chk("full", 64'(full), 64'(e_full));
        chk("empty", 64'(empty), 64'(e_empty));
        chk("dependent", 64'(dep), 64'(e_dep));
        chk("scbid", 64'(sid), 64'(e_sid));
        chk("count", 64'(cnt), 64'(e_cnt));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic model_update();
        bit clr [NW][D];
        int tgt [NW];
        int w, e;
        if (rst) begin
            for (int i = 0; i < NW; i++)
                for (int j = 0; j < D; j++) begin
                    m_busy[i][j] = 0; m_dv[i][j] = 0; m_dst[i][j] = 0;
                end
            m_err = '0;
            return;
        end
        for (int i = 0; i < NW; i++)
            for (int j = 0; j < D; j++) clr[i][j] = 0;
        for (int p = 0; p < NC; p++) begin
            if (cv[p]) begin
                w = int'(cw[p*LW +: LW]);
                e = int'(cs[p*LD +: LD]);
                if (!m_busy[w][e]) m_err[1] = 1'b1;
                else clr[w][e] = 1;
            end
        end
        for (int i = 0; i < NW; i++) begin
            tgt[i] = -1;
            if (alloc[i]) begin
                for (int j = 0; j < D; j++)
                    if (tgt[i] < 0 && !(m_busy[i][j] && !(BYPASS && clr_hit(i, j)))) tgt[i] = j;
                if (tgt[i] < 0) m_err[0] = 1'b1;
            end
        end
        for (int i = 0; i < NW; i++) begin
            for (int j = 0; j < D; j++) if (clr[i][j]) m_busy[i][j] = 0;
            if (tgt[i] >= 0) begin
                m_busy[i][tgt[i]] = 1;
                m_dv[i][tgt[i]]   = dv[i];
                m_dst[i][tgt[i]]  = int'(dst[i*RW +: RW]);
            end
        end
    endtask

    task automatic step();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alloc = '0; s1 = '0; s2 = '0; dst = '0; s1v = '0; s2v = '0; dv = '0;
        cv = '0; cw = '0; cs = '0;
        b_alloc = '0; b_s1 = '0; b_s2 = '0; b_dst = '0; b_s1v = '0; b_s2v = '0; b_dv = '0;
        b_cv = '0; b_cw = '0; b_cs = '0;
    endtask

    task automatic set_warp(input int w, input logic a, input int r1, input logic v1,
                            input int r2, input logic v2, input int rd, input logic vd);
        alloc[w] = a;
        s1[w*RW +: RW] = RW'(r1);  s1v[w] = v1;
        s2[w*RW +: RW] = RW'(r2);  s2v[w] = v2;
        dst[w*RW +: RW] = RW'(rd); dv[w] = vd;
    endtask

    task automatic set_clr(input int p, input int w, input int e);
        cv[p] = 1'b1;
        cw[p*LW +: LW] = LW'(w);
        cs[p*LD +: LD] = LD'(e);
    endtask

    initial begin
        int w, e;
        bit found;
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_empty", 64'(empty), 64'(8'hff));
        chk("rst_dep", 64'(dep), 64'(0));
        chk("rst_sid", 64'(sid), 64'(0));
        chk("rst_cnt", 64'(cnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        set_warp(3, 1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("w3_sid", 64'(sid[3*LD +: LD]), 64'(i));
            step();
        end
        chk("w3_full", 64'(full[3]), 64'(1));
        chk("w3_cnt", 64'(cnt[3*(LD+1) +: LD+1]), 64'(4));
        chk("w3_empty", 64'(empty[3]), 64'(0));
        step();
        idle();
        #1 chk("w3_err0", 64'(err[0]), 64'(1));

        rst = 1'b1; step(); rst = 1'b0;
        set_warp(0, 1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1); step(); idle();
        set_warp(0, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0);
        #1 chk("raw_src2", 64'(dep[0]), 64'(1));
        s2v[0] = 1'b0;
        #1 chk("src2_invalid", 64'(dep[0]), 64'(0));
        set_warp(0, 1'b0, 0, 1'b0, 0, 1'b0, 5, 1'b1);
        #1 chk("waw_dst", 64'(dep[0]), 64'(1));
        step(); idle();

        set_warp(2, 1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1); step(); step(); idle();
        set_clr(0, 2, 1); set_clr(1, 2, 1); step(); idle();
        #1;
        chk("dupclr_cnt", 64'(cnt[2*(LD+1) +: LD+1]), 64'(1));
        chk("dupclr_err1", 64'(err[1]), 64'(0));
        chk("dupclr_sid", 64'(sid[2*LD +: LD]), 64'(1));

        for (int i = 0; i < 4; i++) begin
            set_warp(1, 1'b1, 0, 1'b0, 0, 1'b0, i + 1, 1'b1); step();
        end
        idle();
        set_warp(1, 1'b1, 0, 1'b0, 0, 1'b0, 20, 1'b1); set_clr(0, 1, 2); step(); idle();
        #1;
        chk("fullclr_cnt", 64'(cnt[1*(LD+1) +: LD+1]), 64'(BYPASS ? 4 : 3));
        chk("fullclr_err0", 64'(err[0]), 64'(BYPASS ? 0 : 1));
        chk("fullclr_sid", 64'(sid[1*LD +: LD]), 64'(BYPASS ? 0 : 2));

        set_warp(4, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b0); step(); idle();
        set_warp(4, 1'b0, 9, 1'b1, 9, 1'b1, 9, 1'b1);
        #1 chk("branch_nodep", 64'(dep[4]), 64'(0));
        step(); idle();
        set_clr(1, 4, 0); step(); idle();
        #1 chk("branch_empty", 64'(empty[4]), 64'(1));

        for (int c = 0; c < 500; c++) begin
            idle();
            rst = ($urandom_range(63) == 0);
            for (int i = 0; i < NW; i++)
                set_warp(i, ($urandom_range(2) == 0), $urandom_range(7), $urandom_range(1) == 1,
                         $urandom_range(7), $urandom_range(1) == 1,
                         $urandom_range(7), $urandom_range(3) != 0);
            for (int p = 0; p < NC; p++) begin
                if ($urandom_range(2) != 0) begin
                    w = $urandom_range(NW - 1);
                    e = $urandom_range(D - 1);
                    found = 0;
                    if ($urandom_range(7) != 0)
                        for (int k = 0; k < D; k++)
                            if (!found && m_busy[w][(e + k) % D]) begin
                                e = (e + k) % D;
                                found = 1;
                            end
                    set_clr(p, w, e);
                end
            end
            step();
        end

        idle();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < D2; i++) begin
            b_alloc[15] = 1'b1; b_dst[15*RW +: RW] = RW'(i); b_dv[15] = 1'b1;
            #1 chk("big_sid_walk", 64'(b_sid[15*LD2 +: LD2]), 64'(i));
            step();
        end
        idle();
        #1;
        chk("big_full15", 64'(b_full[15]), 64'(1));
        chk("big_cnt15", 64'(b_cnt[15*(LD2+1) +: LD2+1]), 64'(8));
        chk("big_others_full", 64'(b_full[14:0]), 64'(0));
        b_cv[2] = 1'b1; b_cw[2*LW2 +: LW2] = 4'd15; b_cs[2*LD2 +: LD2] = 3'd5;
        step(); idle();
        #1;
        chk("big_full15_clr", 64'(b_full[15]), 64'(0));
        chk("big_sid15", 64'(b_sid[15*LD2 +: LD2]), 64'(5));
        chk("big_cnt15_clr", 64'(b_cnt[15*(LD2+1) +: LD2+1]), 64'(7));
        chk("big_others_cnt", 64'(b_cnt[59:0]), 64'(0));
        chk("big_others_empty", 64'(b_empty[14:0]), 64'(16'h7fff));
        chk("big_err", 64'(b_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
